radical: RTL and testbench

Iterative integer k-th root unit: given a 16-bit radicand `A` and a 16-bit exponent `B`, it computes `R = floor(A^(1/B))` using a start/ack handshake. It is the inverse of the power block (`A^B`) already in the arithmetic library and uses the same request/acknowledge protocol, so a controller can drive either block the same way. The root is found by MSB-first binary search over the 16 result bits. Each candidate is raised to the B-th power by repeated calls to an internal shift-add multiplier, and the calculation stops early as soon as the partial power exceeds `A`.

---
 rtl/radical_pkg.sv | 9 +
 rtl/mul_sa.sv | 53 +++++
 rtl/radical.sv | 113 +++++++++++
 tb/tb_radical.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/radical_pkg.sv
// Shared types and constants for the iterative integer k-th root unit.
package radical_pkg;
  localparam int WIDTH_DEFAULT = 16;
  localparam int PWIDTH        = 2 * WIDTH_DEFAULT;

  typedef enum logic [2:0] {
    IDLE, CHECK, TRY, MSTART, MWAIT, TEST, NEXT, DONE
  } radical_state_t;
endpackage

// File: rtl/mul_sa.sv
// WIDTH x WIDTH -> 2*WIDTH shift-add multiplier; start sampled when idle,
// WIDTH add cycles, then a single-cycle ack with P held until the next start.
module mul_sa
  import radical_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] P,
  output logic               ack
);
  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mc;
  logic [WIDTH-1:0]   mp;
  logic [CW-1:0]      cnt;
  logic               busy;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      mc   <= '0;
      mp   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      P    <= '0;
      ack  <= 1'b0;
    end else begin
      ack <= 1'b0;
      if (!busy) begin
        if (start) begin
          mc   <= {{WIDTH{1'b0}}, A};
          mp   <= B;
          P    <= '0;
          cnt  <= '0;
          busy <= 1'b1;
        end
      end else begin
        if (mp[0]) P <= P + mc;
        mc  <= mc << 1;
        mp  <= mp >> 1;
        cnt <= cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          busy <= 1'b0;
          ack  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/radical.sv
// R = floor(A^(1/B)) by MSB-first binary search, powering each candidate with mul_sa.
// Optional RADICAL_FASTPATH_EN resolves B==1 and B>=WIDTH directly in CHECK.
module radical
  import radical_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] R,
  output logic             ack,
  output logic             err
);
  localparam int PW = 2 * WIDTH;
  localparam int IW = $clog2(WIDTH);

  radical_state_t   state, state_nxt;
  logic [WIDTH-1:0] x, k, c, n;
  logic [PW-1:0]    p, mul_p;
  logic [IW-1:0]    i;
  logic             mul_go, mul_ack, over;

  // P never exceeds X before a multiply, so its low half is the full operand.
  mul_sa #(.WIDTH(WIDTH)) u_mul (
    .Clk   (Clk),
    .Rst   (Rst),
    .start (mul_go),
    .A     (p[WIDTH-1:0]),
    .B     (c),
    .P     (mul_p),
    .ack   (mul_ack)
  );

  assign over = p > PW'(x);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mul_go    = 1'b0;
    case (state)
      IDLE:   if (start) state_nxt = CHECK;
      CHECK: begin
        state_nxt = TRY;
        if (k == '0 || x == '0) state_nxt = DONE;
`ifdef RADICAL_FASTPATH_EN
        else if (k == WIDTH'(1) || k >= WIDTH'(WIDTH)) state_nxt = DONE;
`endif
      end
      TRY:    state_nxt = MSTART;
      MSTART: begin
        mul_go    = 1'b1;
        state_nxt = MWAIT;
      end
      MWAIT:  if (mul_ack) state_nxt = TEST;
      TEST:   state_nxt = (over || n == '0) ? NEXT : MSTART;
      NEXT:   state_nxt = (i == '0) ? DONE : TRY;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      x   <= '0;
      k   <= '0;
      c   <= '0;
      n   <= '0;
      p   <= '0;
      i   <= '0;
      R   <= '0;
      ack <= 1'b0;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          x   <= A;
          k   <= B;
          R   <= '0;
          ack <= 1'b0;
          err <= 1'b0;
          i   <= IW'(WIDTH - 1);
        end
        CHECK: begin
          if (k == '0) err <= 1'b1;
`ifdef RADICAL_FASTPATH_EN
          else if (x != '0 && k == WIDTH'(1))     R <= x;
          else if (x != '0 && k >= WIDTH'(WIDTH)) R <= WIDTH'(1);
`endif
        end
        TRY: begin
          c <= R | (WIDTH'(1) << i);
          p <= PW'(1);
          n <= k;
        end
        MWAIT: if (mul_ack) begin
          p <= mul_p;
          n <= n - 1'b1;
        end
        TEST: if (!over && n == '0) R <= c;
        NEXT: if (i != '0) i <= i - 1'b1;
        DONE: ack <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_radical.sv
// Directed and random checks of radical against a linear-search root model.
module tb_radical;
  logic        Clk = 1'b0;
  logic        Rst;
  logic        start;
  logic [15:0] A, B;
  logic [15:0] R;
  logic        ack, err;

  int n_cmp = 0;
  int n_bad = 0;

  radical dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .start (start),
    .A     (A),
    .B     (B),
    .R     (R),
    .ack   (ack),
    .err   (err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Smallest r with (r+1)^b > a, found by counting upward.
  function automatic longint iroot(input longint a, input longint b);
    longint pw;
    if (b == 0 || a == 0) return 0;
    for (longint cand = 1; cand <= 65536; cand++) begin
      pw = 1;
      for (longint j = 0; j < b; j++) begin
        pw = pw * cand;
        if (pw > a) break;
      end
      if (pw > a) return cand - 1;
    end
    return 65535;
  endfunction

  // Issue one request, check handshake, result and error; report latency
  // as edges from the accepting edge (1) to the edge that raises ack.
  task automatic req(input logic [15:0] a, input logic [15:0] b,
                     input string tag, output int lat);
    int bound;
    bound = 3 + 16 * (2 + 19 * int'(b)) + 4;
    @(negedge Clk);
    A = a; B = b; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    lat = 1;
    chk({tag, "_ackclr"}, ack, 0);
    while (!ack && lat < bound) begin
      @(posedge Clk); #1;
      lat++;
    end
    chk({tag, "_done"}, ack, 1);
    chk({tag, "_R"},   R,   iroot(a, b));
    chk({tag, "_err"}, err, (b == 0) ? 1 : 0);
  endtask

  typedef struct { logic [15:0] a, b; } vec_t;

  initial begin
    int lat;
    logic [15:0] r_hold;
    vec_t dv[$];

    Rst = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_R",   R,   0);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    @(negedge Clk);
    Rst = 1'b0;

    req(16'd27, 16'd3, "r27_3", lat);
    req(16'd26, 16'd3, "r26_3", lat);
    req(16'd65535, 16'd2, "r65535_2", lat);
    req(16'd65535, 16'd1, "r65535_1", lat);
`ifdef RADICAL_FASTPATH_EN
    chk("r65535_1_lat", lat, 3);
`else
    chk("r65535_1_slow", (lat > 3) ? 1 : 0, 1);
`endif
    req(16'd0, 16'd5, "r0_5", lat);
    chk("r0_5_lat", lat, 3);
    req(16'd9, 16'd0, "r9_0", lat);
    chk("r9_0_lat", lat, 3);
    req(16'd1000, 16'd20, "r1000_20", lat);
`ifdef RADICAL_FASTPATH_EN
    chk("r1000_20_lat", lat, 3);
    req(16'd1, 16'd65535, "r1_65535", lat);
    chk("r1_65535_lat", lat, 3);
`else
    req(16'd1, 16'd100, "r1_100", lat);
`endif

    // start while busy must be ignored
    @(negedge Clk);
    A = 16'd27; B = 16'd3; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    repeat (30) @(posedge Clk);
    @(negedge Clk);
    A = 16'd8; B = 16'd3; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    lat = 0;
    while (!ack && lat < 2000) begin
      @(posedge Clk); #1;
      lat++;
    end
    chk("busy_done", ack, 1);
    chk("busy_R", R, 3);
    r_hold = R;
    repeat (5) @(posedge Clk);
    #1;
    chk("busy_hold_ack", ack, 1);
    chk("busy_hold_R", R, r_hold);

    // reset in the middle of a search
    @(negedge Clk);
    A = 16'd50000; B = 16'd2; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    repeat (500) @(posedge Clk);
    #2 Rst = 1'b1;
    #1;
    chk("midrst_R",   R,   0);
    chk("midrst_ack", ack, 0);
    chk("midrst_err", err, 0);
    @(negedge Clk);
    Rst = 1'b0;
    req(16'd49, 16'd2, "r49_2", lat);

    // edge-ish directed set plus a random sweep
    dv.push_back('{16'd1, 16'd1});
    dv.push_back('{16'd4, 16'd2});
    dv.push_back('{16'd3, 16'd2});
    dv.push_back('{16'd32768, 16'd15});
    dv.push_back('{16'd65535, 16'd16});
    dv.push_back('{16'd65535, 16'd0});
    foreach (dv[j]) req(dv[j].a, dv[j].b, $sformatf("dv%0d", j), lat);
    for (int j = 0; j < 80; j++)
      req(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 20)),
          $sformatf("rnd%0d", j), lat);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
